// File: rtl/rr_handshake_arbiter.sv
// rr_handshake_arbiter
//   Merges NUM_REQ valid/ready requesters onto one registered downstream channel.
//   Round-robin grant between packets; once a requester's first beat (last=0) is taken, the
//   channel stays locked to it until its last beat is accepted. The output slice gives
//   one-cycle latency and full throughput (it reloads on the same edge it drains).
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   valid_up    per-requester beat valid
//   data_up     requester i data at [i*WIDTH +: WIDTH]
//   last_up     per-requester last beat of packet
//   ready_up    per-requester accept, at most one bit high
//   valid_down  output register holds a beat
//   data_down   registered beat data
//   last_down   registered last flag
//   src_down    index of the requester that sent the held beat
//   ready_down  downstream accept
module rr_handshake_arbiter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       valid_up,
    input  logic [NUM_REQ*WIDTH-1:0] data_up,
    input  logic [NUM_REQ-1:0]       last_up,
    output logic [NUM_REQ-1:0]       ready_up,
    output logic                     valid_down,
    output logic [WIDTH-1:0]         data_down,
    output logic                     last_down,
    output logic [IDX_W-1:0]         src_down,
    input  logic                     ready_down
);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] owner_q;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;
    logic [IDX_W-1:0] src_q;

    logic             load;
    logic             accept;
    logic             grant_valid;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] grant_next;
    logic             hi_found;
    logic             lo_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             owner_valid;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic [NUM_REQ-1:0] ready_c;

    assign load = !valid_q || ready_down;

    // Round-robin scan split in two passes: the first valid index at or above ptr wins,
    // otherwise the first valid index below ptr (the wrapped part of the scan).
    always_comb begin
        hi_found    = 1'b0;
        lo_found    = 1'b0;
        hi_idx      = '0;
        lo_idx      = '0;
        owner_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (valid_up[i]) begin
                if (IDX_W'(i) >= ptr_q) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = IDX_W'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(i);
                end
            end
            if (IDX_W'(i) == owner_q) begin
                owner_valid = valid_up[i];
            end
        end
    end

    // While locked only the owner may be granted, even when it is idle.
    always_comb begin
        if (state_q == ST_LOCK) begin
            grant       = owner_q;
            grant_valid = owner_valid;
        end else begin
            grant       = hi_found ? hi_idx : lo_idx;
            grant_valid = hi_found || lo_found;
        end
    end

    assign accept     = load && grant_valid;
    assign grant_next = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        ready_c  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == grant) begin
                sel_data   = data_up[i*WIDTH +: WIDTH];
                sel_last   = last_up[i];
                ready_c[i] = accept;
            end
        end
    end

    // Reset holds every requester off, independent of the registered state.
    assign ready_up = rst ? ready_c : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            src_q   <= '0;
        end else begin
            if (accept) begin
                valid_q <= 1'b1;
                data_q  <= sel_data;
                last_q  <= sel_last;
                src_q   <= grant;
                if (sel_last) begin
                    // In LOCK grant equals owner, so this also advances past the owner.
                    state_q <= ST_ARB;
                    ptr_q   <= grant_next;
                end else begin
                    state_q <= ST_LOCK;
                    owner_q <= grant;
                end
            end else if (ready_down) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_down = valid_q;
    assign data_down  = data_q;
    assign last_down  = last_q;
    assign src_down   = src_q;

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
module tb_rr_handshake_arbiter;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    vu;
    logic [N*W-1:0]  du;
    logic [N-1:0]    lu;
    logic [N-1:0]    ready_up;
    logic            valid_down;
    logic [W-1:0]    data_down;
    logic            last_down;
    logic [IW-1:0]   src_down;
    logic            ready_down;

    rr_handshake_arbiter #(.WIDTH(W), .NUM_REQ(N), .IDX_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_up   (vu),
        .data_up    (du),
        .last_up    (lu),
        .ready_up   (ready_up),
        .valid_down (valid_down),
        .data_down  (data_down),
        .last_down  (last_down),
        .src_down   (src_down),
        .ready_down (ready_down)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Per-requester beat queues (data, last); head advances when the model accepts.
    int bdata [N][16];
    bit blast [N][16];
    int head  [N];
    int tail  [N];
    bit en    [N];

    // Spec-level model: output register contents, pointer, lock owner.
    bit m_valid, m_last, m_cleared, m_locked;
    int m_data, m_src, m_ptr, m_owner;

    int log_src[$];
    int log_data[$];
    int log_cyc[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int r, input int d, input bit l);
        bdata[r][tail[r]] = d;
        blast[r][tail[r]] = l;
        tail[r]++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_src.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    // Expected sequences packed as nibbles, beat k at [k*4 +: 4].
    task automatic check_log(input string name, input int n, input logic [31:0] src_pk,
                             input logic [31:0] data_pk, input bit contig);
        check({name, "_count"}, log_src.size(), n);
        for (int k = 0; k < n && k < log_src.size(); k++) begin
            check({name, "_src"}, log_src[k], int'(src_pk[k*4 +: 4]));
            check({name, "_data"}, log_data[k], int'(data_pk[k*4 +: 4]));
            if (contig && k > 0) check({name, "_gap"}, log_cyc[k] - log_cyc[k-1], 1);
        end
    endtask

    function automatic int pick_grant();
        int i;
        if (m_locked) return vu[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (vu[i]) return i;
        end
        return -1;
    endfunction

    // Requester driver, per-cycle compare, and model update.
    initial begin
        int         g;
        bit         acc;
        logic [N-1:0] exp_ru;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (head[i] < tail[i]) begin
                    vu[i]          = en[i];
                    du[i*W +: W]   = W'(bdata[i][head[i]]);
                    lu[i]          = blast[i][head[i]];
                end else begin
                    vu[i]          = 1'b0;
                    du[i*W +: W]   = '0;
                    lu[i]          = 1'b0;
                end
            end
            #3;
            g      = pick_grant();
            acc    = rst && (!m_valid || ready_down) && (g >= 0);
            exp_ru = acc ? N'(1 << g) : '0;
            check("ready_up", int'(ready_up), int'(exp_ru));
            check("valid_down", int'(valid_down), int'(m_valid));
            if (m_valid || m_cleared) begin
                check("data_down", int'(data_down), m_data);
                check("last_down", int'(last_down), int'(m_last));
                check("src_down", int'(src_down), m_src);
            end
            if (rst && valid_down && ready_down) begin
                log_src.push_back(int'(src_down));
                log_data.push_back(int'(data_down));
                log_cyc.push_back(cyc);
            end
            @(posedge clk);
            cyc++;
            if (!rst) begin
                m_valid   = 1'b0;
                m_last    = 1'b0;
                m_data    = 0;
                m_src     = 0;
                m_ptr     = 0;
                m_locked  = 1'b0;
                m_owner   = 0;
                m_cleared = 1'b1;
            end else if (acc) begin
                m_valid   = 1'b1;
                m_data    = bdata[g][head[g]];
                m_last    = blast[g][head[g]];
                m_src     = g;
                m_cleared = 1'b0;
                if (m_last) begin
                    m_locked = 1'b0;
                    m_ptr    = (g + 1) % N;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end
                head[g]++;
            end else if (ready_down) begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        rst        = 1'b0;
        ready_down = 1'b1;
        vu         = '0;
        du         = '0;
        lu         = '0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            en[i]   = 1'b1;
        end
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_data    = 0;
        m_src     = 0;
        m_ptr     = 0;
        m_locked  = 1'b0;
        m_owner   = 0;
        m_cleared = 1'b1;

        // Reset with every requester valid.
        push(0, 1, 1'b1);
        push(1, 2, 1'b1);
        push(2, 3, 1'b1);
        push(3, 4, 1'b1);
        push(0, 1, 1'b1);
        tick(2);
        check("rst_valid_down", int'(valid_down), 0);
        check("rst_ready_up", int'(ready_up), 0);
        check("rst_src_down", int'(src_down), 0);

        // Rotation of single-beat packets, one beat per cycle.
        rst = 1'b1;
        clear_log();
        tick(8);
        check_log("rotation", 5, 32'h0000_3210, 32'h0001_4321, 1'b1);

        // Packet lock: req1 A,B,C while req0 and req2 wait; ptr starts at 1.
        clear_log();
        push(1, 10, 1'b0);
        push(1, 11, 1'b0);
        push(1, 12, 1'b1);
        push(0, 6, 1'b1);
        push(2, 7, 1'b1);
        tick(10);
        check_log("lock", 5, 32'h0000_2111, 32'h0006_7CBA, 1'b1);

        // Backpressure with data 5 held.
        clear_log();
        ready_down = 1'b0;
        push(1, 5, 1'b1);
        push(2, 8, 1'b1);
        tick(1);
        check("bp_loaded", int'(data_down), 5);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("bp_hold_data", int'(data_down), 5);
            check("bp_hold_valid", int'(valid_down), 1);
            check("bp_hold_ready_up", int'(ready_up), 0);
        end
        ready_down = 1'b1;
        tick(1);
        check("bp_next_data", int'(data_down), 8);
        check("bp_next_src", int'(src_down), 2);
        tick(3);
        check_log("bp", 2, 32'h0000_0021, 32'h0000_0085, 1'b1);

        // Owner gap: req2 owns the channel and goes idle while req3 is valid.
        clear_log();
        en[3] = 1'b0;
        push(2, 1, 1'b0);
        push(2, 2, 1'b0);
        push(2, 3, 1'b1);
        push(3, 9, 1'b1);
        tick(1);
        en[2] = 1'b0;
        en[3] = 1'b1;
        tick(2);
        check("gap_ready_up", int'(ready_up), 0);
        check("gap_valid_down", int'(valid_down), 0);
        en[2] = 1'b1;
        tick(8);
        check_log("gap", 4, 32'h0000_3222, 32'h0000_9321, 1'b0);

        // Reset after beat 1 of a req0 packet; req1 must then win.
        clear_log();
        en[1] = 1'b0;
        push(0, 4, 1'b0);
        push(0, 5, 1'b0);
        push(0, 6, 1'b1);
        push(1, 13, 1'b1);
        tick(1);
        rst     = 1'b0;
        head[0] = tail[0];
        en[0]   = 1'b0;
        en[1]   = 1'b1;
        tick(1);
        check("midrst_valid_down", int'(valid_down), 0);
        check("midrst_ready_up", int'(ready_up), 0);
        check("midrst_src_down", int'(src_down), 0);
        rst = 1'b1;
        tick(5);
        check_log("midrst", 1, 32'h0000_0001, 32'h0000_000D, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
